// File: rtl/param_sync_fifo.sv
// Synchronous FIFO with registered read data, occupancy count and threshold flags.
// Define FIFO_ERR_FLAGS_EN to build sticky overflow/underflow flags; otherwise both are tied to 0.
module param_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int AF_LVL = DEPTH - 2,
    parameter int AE_LVL = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write_en,
    input  logic              read_en,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] out,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CW-1:0]     count,
    output logic              overflow,
    output logic              underflow
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              wr_acc;
    logic              rd_acc;

    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CW'(AF_LVL));
    assign almost_empty = (count <= CW'(AE_LVL));

    // Gating on the current flags makes simultaneous read+write at full/empty accept only the legal side.
    assign wr_acc = write_en && !full;
    assign rd_acc = read_en && !empty;

    // NOTE: the storage array has no reset; pointers and count define validity, so stale words are never read.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            out    <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + AW'(1);
                out    <= mem[rd_ptr];
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    // Flags record the request, not the acceptance, and stay set until reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (write_en && full) begin
                overflow <= 1'b1;
            end
            if (read_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 8, number of storage entries (power of 2, >=4).
REQ-003 SHALL have parameter AF_LVL, default DEPTH-2, almost_full threshold in entries.
REQ-004 SHALL have parameter AE_LVL, default 2, almost_empty threshold in entries.
REQ-005 SHALL define CW = log2(DEPTH)+1 as the count width.
REQ-006 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port write_en, input, 1, write request.
REQ-009 SHALL have port read_en, input, 1, read request.
REQ-010 SHALL have port data_in, input, DATA_W, write data.
REQ-011 SHALL have port out, output, DATA_W, registered read data.
REQ-012 SHALL have port full, output, 1, count == DEPTH.
REQ-013 SHALL have port empty, output, 1, count == 0.
REQ-014 SHALL have port almost_full, output, 1, count >= AF_LVL.
REQ-015 SHALL have port almost_empty, output, 1, count <= AE_LVL.
REQ-016 SHALL have port count, output, CW, current occupancy 0..DEPTH.
REQ-017 SHALL have ports overflow and underflow, output, 1 each, sticky error flags (see Configuration).

Function
REQ-018 SHALL accept a write iff write_en=1 and full=0 at the rising edge; data_in stored at write pointer, pointer +1.
REQ-019 SHALL accept a read iff read_en=1 and empty=0 at the rising edge; out loads entry at read pointer, pointer +1.
REQ-020 SHALL present read data on out one cycle after the accepting edge; out holds its value when no read is accepted.
REQ-021 SHALL wrap both pointers from DEPTH-1 to 0 (log2(DEPTH)-bit modulo arithmetic).
REQ-022 SHALL update count by accepted operations only: +1 write-only, -1 read-only, unchanged for both or neither.
REQ-023 SHALL, with write and read both requested while full, accept only the read; count goes DEPTH-1.
REQ-024 SHALL, with write and read both requested while empty, accept only the write; out unchanged; count goes 1.
REQ-025 SHALL derive full, empty, almost_full, almost_empty combinationally from count only.
REQ-026 SHALL never alter stored data or pointers on a rejected request.

Reset
REQ-027 SHALL, on reset=0, immediately and independent of clk, clear pointers, count, out, overflow, underflow to 0.
REQ-028 SHALL, during reset, drive empty=1, full=0, almost_empty=1, almost_full=0.
REQ-029 SHALL discard all contents on reset asserted mid-operation; storage array need not be cleared.
REQ-030 SHALL resume accepting requests on the first rising edge after reset deasserts.

Configuration
REQ-031 SHALL compile sticky error flags only when macro FIFO_ERR_FLAGS_EN is defined.
REQ-032 SHALL, with FIFO_ERR_FLAGS_EN, set overflow on a write requested while full and underflow on a read requested while empty; both hold until reset.
REQ-033 SHALL, without FIFO_ERR_FLAGS_EN, tie overflow and underflow to constant 0 with no associated registers.

Verification (DATA_W=8, DEPTH=8, AF_LVL=6, AE_LVL=2)
REQ-034 SHALL cover: reset, write 0x01..0x08 -> full=1 after 8th edge, count=8, almost_full from 6th write onward.
REQ-035 SHALL cover: from full, read 8 times -> out 0x01..0x08 in order, each one cycle after its edge; empty=1 after 8th read.
REQ-036 SHALL cover: write+read every cycle for 20 cycles at count=3 -> count stays 3, data in order across pointer wrap.
REQ-037 SHALL cover: full plus write_en=read_en=1 -> count 7, extra word dropped; with FIFO_ERR_FLAGS_EN overflow=1 and held.
REQ-038 SHALL cover: empty plus read_en=1 -> out unchanged, count 0; with FIFO_ERR_FLAGS_EN underflow=1.
REQ-039 SHALL cover: reset asserted mid-clock at count=5 -> count=0, empty=1, out=0 before next edge.
